mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder.
- FSM sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared instruction/data memory with a ready handshake.
- Emits per-state datapath strobes and a parametrised ALU operation code.
- Counts illegal opcodes for debug.
- Sits between the instruction register opcode field and the multicycle datapath, memory port and PC register.

Parameters:
- ALUOP_W, 3, width of alu_op; must be >=3; codes are zero-extended into it.
- ILL_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- op  input  6  opcode, instr[31:26], from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load gated by ALU zero (beq).
- pc_src  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- iord  output  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write register select: 1 rd, 0 rt.
- mem_to_reg  output  1  write-back data select: 1 MDR, 0 ALUOut.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 PC, 1 rs.
- alu_src_b  output  2  ALU B select: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_op  output  ALUOP_W  ALU operation code (see Behaviour).
- state  output  4  current state, debug.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- ill_count  output  ILL_CNT_W  saturating count of illegal opcodes.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, ill_count=0.
  - All outputs take their FETCH values with mem_ready treated as 0: mem_read=1, alu_src_b=01, all other strobes 0.
- alu_op codes:
  - 000 add, 001 R-type (funct decides), 010 slt, 011 and, 100 or, 101 sub.
- State encoding and outputs. Outputs are Moore except where marked. Any strobe not listed is 0; unlisted mux selects are 0.
  - FETCH=0: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=add.
    - ir_write and pc_write equal mem_ready (Mealy), pc_src=00.
    - Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_op=add (precompute branch target).
    - Next state by op:
      - lw 100011 or sw 101011 -> MEMADR.
      - R 000000, addi 001000, andi 001100, ori 001101, slti 001010 -> EXEC.
      - beq 000100 -> BRANCH.
      - anything else -> ILLEGAL.
  - MEMADR=2: alu_src_a=1, alu_src_b=10, alu_op=add.
    - Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD=3: iord=1, mem_read=1.
    - Wait for mem_ready, then go to MEMWB.
  - MEMWB=4: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR=5: iord=1, mem_write=1.
    - Wait for mem_ready, then go to FETCH.
  - EXEC=6: alu_src_a=1.
    - R-type: alu_src_b=00, alu_op=001.
    - addi: alu_src_b=10, alu_op=000.
    - slti: alu_src_b=10, alu_op=010.
    - andi: alu_src_b=10, alu_op=011.
    - ori: alu_src_b=10, alu_op=100.
    - Next: ALUWB.
  - ALUWB=7: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type else 0. Next: FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=101, pc_write_cond=1, pc_src=01.
    - reg_write=0. Next: FETCH.
  - JUMP=9: pc_write=1, pc_src=10. Next: FETCH.
  - ILLEGAL=10: illegal_op=1; ill_count increments, saturating at all-ones.
    - No register or memory write; PC already advanced. Next: FETCH.
  - Encodings 11-15: unreachable; if entered, go to FETCH next cycle.
- op is sampled in DECODE, MEMADR and EXEC. op must stay stable from the FETCH completion until the next FETCH; the instruction register holds it.
- Latencies with mem_ready tied to 1:
  - lw 5 cycles.
  - sw, R-type and I-type ALU 4 cycles.
  - beq and j 3 cycles.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction aborts it immediately; no partial write strobe survives the reset edge.

Optional Feature:
- Macro MIPS_MCU_JUMP_EN.
- Defined: op 000010 (j) goes DECODE -> JUMP, and pc_src=10 is used.
- Undefined: the JUMP state is absent, op 000010 goes to ILLEGAL, and pc_src never takes the value 10.

Test Plan:
1. Reset with rst_n=0 mid-MEMRD -> state=0, mem_read=1, ill_count=0, reg_write=0, mem_write=0 asynchronously.
2. op=100011, mem_ready=1 throughout -> states 0,1,2,3,4; reg_write=1 with mem_to_reg=1 only in state 4; 5 cycles.
3. op=101011, mem_ready low 3 cycles in MEMWR -> mem_write=1 held 4 cycles, iord=1; then FETCH; reg_write never asserted.
4. op=000000, then 001101 -> R: alu_op=001 in EXEC, reg_dst=1 in ALUWB; ori: alu_op=100, alu_src_b=10, reg_dst=0.
5. op=000100 -> BRANCH with alu_op=101, pc_write_cond=1, pc_src=01, reg_write=0; 3 cycles.
6. op=111111 repeated 300 times with ILL_CNT_W=8 -> illegal_op pulses once per instruction; ill_count saturates at 255. op=000010 -> JUMP with MIPS_MCU_JUMP_EN defined, ILLEGAL without it.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with a mem_ready handshake.
// The optional jump instruction is enabled by defining MIPS_MCU_JUMP_EN.
module mips_multicycle_control #(
  parameter int ALUOP_W   = 3,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           op,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_src,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic [3:0]           state,
  output logic                 illegal_op,
  output logic [ILL_CNT_W-1:0] ill_count
);

  // state   | meaning
  // FETCH   | read instruction at PC, PC+4 on mem_ready
  // DECODE  | precompute branch target, dispatch on op
  // MEMADR  | compute load/store address
  // MEMRD   | load data read, wait for mem_ready
  // MEMWB   | write loaded data to rt
  // MEMWR   | store data write, wait for mem_ready
  // EXEC    | R-type / I-type ALU operation
  // ALUWB   | write ALU result to rd or rt
  // BRANCH  | beq compare and conditional PC load
  // JUMP    | unconditional jump (optional)
  // ILLEGAL | unsupported opcode, count it
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
`ifdef MIPS_MCU_JUMP_EN
    JUMP    = 4'd9,
`endif
    ILLEGAL = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MIPS_MCU_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_t curState;
  state_t nextState;
  logic   pcWriteJump;
  logic   fetchDone;

  assign state     = curState;
  // Mealy strobes are gated by rst_n so reset presents FETCH with mem_ready treated as 0.
  assign fetchDone = (curState == FETCH) && mem_ready && rst_n;
  assign ir_write  = fetchDone;
  assign pc_write  = fetchDone || pcWriteJump;

  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:  nextState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                                  nextState = MEMADR;
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   nextState = EXEC;
          OP_BEQ:                                        nextState = BRANCH;
`ifdef MIPS_MCU_JUMP_EN
          OP_J:                                          nextState = JUMP;
`endif
          default:                                       nextState = ILLEGAL;
        endcase
      end
      MEMADR: nextState = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nextState = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nextState = mem_ready ? FETCH : MEMWR;
      EXEC:   nextState = ALUWB;
      default: nextState = FETCH;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState      <= FETCH;
      pcWriteJump   <= 1'b0;
      pc_write_cond <= 1'b0;
      pc_src        <= 2'b00;
      iord          <= 1'b0;
      mem_read      <= 1'b1;
      mem_write     <= 1'b0;
      reg_dst       <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_write     <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b01;
      alu_op        <= '0;
      illegal_op    <= 1'b0;
      ill_count     <= '0;
    end else begin
      curState      <= nextState;
      pcWriteJump   <= 1'b0;
      pc_write_cond <= 1'b0;
      pc_src        <= 2'b00;
      iord          <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      reg_dst       <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_write     <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b00;
      alu_op        <= '0;
      illegal_op    <= 1'b0;
      case (nextState)
        FETCH: begin
          mem_read  <= 1'b1;
          alu_src_b <= 2'b01;
        end
        DECODE: alu_src_b <= 2'b11;
        MEMADR: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
        end
        MEMRD: begin
          iord     <= 1'b1;
          mem_read <= 1'b1;
        end
        MEMWB: begin
          mem_to_reg <= 1'b1;
          reg_write  <= 1'b1;
        end
        MEMWR: begin
          iord      <= 1'b1;
          mem_write <= 1'b1;
        end
        EXEC: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
          case (op)
            OP_RTYPE: begin
              alu_src_b <= 2'b00;
              alu_op    <= ALUOP_W'(3'b001);
            end
            OP_SLTI: alu_op <= ALUOP_W'(3'b010);
            OP_ANDI: alu_op <= ALUOP_W'(3'b011);
            OP_ORI:  alu_op <= ALUOP_W'(3'b100);
            default: alu_op <= ALUOP_W'(3'b000);
          endcase
        end
        ALUWB: begin
          reg_write <= 1'b1;
          reg_dst   <= (op == OP_RTYPE);
        end
        BRANCH: begin
          alu_src_a     <= 1'b1;
          alu_op        <= ALUOP_W'(3'b101);
          pc_write_cond <= 1'b1;
          pc_src        <= 2'b01;
        end
`ifdef MIPS_MCU_JUMP_EN
        JUMP: begin
          pcWriteJump <= 1'b1;
          pc_src      <= 2'b10;
        end
`endif
        ILLEGAL: begin
          illegal_op <= 1'b1;
          if (ill_count != '1) ill_count <= ill_count + ILL_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
